spi_slave: RTL
==============

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter: SPI_MODE, 0, SPI mode 0-3. CPOL = (SPI_MODE is 2 or 3); CPHA = (SPI_MODE is 1 or 3).
REQ-002 Parameter: SYNC_STAGES, 2, number of synchronizer flops on SPI_CLK, CS_n and MOSI; legal values 2-3.
REQ-003 Port: clk, input, 1, system clock; clk SHALL be at least 8x the SPI_CLK frequency.
REQ-004 Port: rst, input, 1, asynchronous active-high reset.
REQ-005 Port: SPI_CLK, input, 1, serial clock from the master (asynchronous to clk).
REQ-006 Port: CS_n, input, 1, active-low chip select from the master.
REQ-007 Port: MOSI, input, 1, serial data from the master, MSB first.
REQ-008 Port: MISO, output, 1, serial data to the master, MSB first.
REQ-009 Port: o_MISO_OE, output, 1, MISO output enable; high only while the synchronized CS_n is low.
REQ-010 Port: i_TX_Byte, input, 8, next byte to return on MISO.
REQ-011 Port: i_TX_DV, input, 1, one-cycle load strobe for i_TX_Byte.
REQ-012 Port: o_TX_Ready, output, 1, TX holding buffer is empty and can accept a byte.
REQ-013 Port: o_RX_Byte, output, 8, last complete byte received on MOSI.
REQ-014 Port: o_RX_DV, output, 1, one-cycle pulse; o_RX_Byte is valid.
REQ-015 Port: o_TX_Underrun, output, 1, one-cycle pulse; a byte was loaded for sending while the TX buffer was empty.
REQ-016 Port: o_Frame_Err, output, 1, one-cycle pulse; CS_n rose mid-byte.
REQ-017 Port: o_Busy, output, 1, high while the state machine is in ACTIVE.

Function
REQ-018 SPI_CLK, CS_n and MOSI SHALL each pass through SYNC_STAGES flops, followed by one edge-detect register; the total event latency from a pin edge is SYNC_STAGES+1 clk cycles.
REQ-019 Leading edge: synchronized SPI_CLK changes from CPOL to ~CPOL. Trailing edge: the reverse. Edges SHALL be ignored while the synchronized CS_n is high.
REQ-020 Capture edge is the leading edge when CPHA=0 and the trailing edge when CPHA=1. Shift edge is the other edge.
REQ-021 The state machine SHALL have two states, IDLE and ACTIVE.
REQ-022 IDLE -> ACTIVE on the synchronized CS_n falling edge. In the same cycle: bit counter = 7; shift register loaded from the TX buffer.
REQ-023 ACTIVE -> IDLE on the synchronized CS_n rising edge.
REQ-024 On each capture edge: the synchronized MOSI SHALL be shifted into the RX shift register (MSB first) and the bit counter decremented by 1, wrapping from 0 to 7.
REQ-025 On the capture edge where the bit counter is 0: o_RX_Byte SHALL be updated and o_RX_DV pulsed on the next clk cycle.
REQ-026 CPHA=0: MISO SHALL present shift-register bit 7 one cycle after the load. Each shift edge advances to the next bit. The 8th shift edge of a byte SHALL reload the shift register from the TX buffer.
REQ-027 CPHA=1: MISO SHALL update to the next bit on each shift edge, starting with bit 7 on the first leading edge. The 8th capture edge SHALL reload the shift register from the TX buffer.
REQ-028 TX buffer: i_TX_DV while o_TX_Ready=1 SHALL store i_TX_Byte and drive o_TX_Ready low on the next cycle. i_TX_DV while o_TX_Ready=0 SHALL be ignored.
REQ-029 A shift-register load SHALL empty the buffer, so o_TX_Ready returns high on the next cycle.
REQ-030 A load from an empty buffer SHALL load 0x00 and pulse o_TX_Underrun.
REQ-031 If i_TX_DV and a load coincide with the buffer empty: i_TX_Byte SHALL go directly to the shift register, with no underrun and the buffer left empty.
REQ-032 CS_n rising with the bit counter not equal to 7 SHALL discard the partial byte, pulse o_Frame_Err, and suppress o_RX_DV.
REQ-033 Multiple bytes per CS_n-low frame SHALL be supported with no idle gap between bytes.
REQ-034 While in IDLE, MISO SHALL hold 0 and o_MISO_OE SHALL be 0.

Reset
REQ-035 rst SHALL asynchronously force: state IDLE; all synchronizers to idle values (SPI_CLK=CPOL, CS_n=1, MOSI=0); bit counter 7; shift registers 0; TX buffer empty.
REQ-036 Output values during reset: MISO=0, o_MISO_OE=0, o_TX_Ready=1, o_RX_Byte=0x00, o_RX_DV=0, o_TX_Underrun=0, o_Frame_Err=0, o_Busy=0.
REQ-037 rst mid-frame SHALL abort with no output pulses. After rst falls, the block SHALL wait for a fresh CS_n falling edge before starting a frame.

Verification
REQ-038 Mode 0, clk = 8x SPI_CLK: preload 0xA5, master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; o_RX_Byte=0x3C; one o_RX_DV pulse.
REQ-039 Modes 1, 2 and 3, same stimulus -> same byte results, with edge usage as in REQ-020, REQ-026 and REQ-027.
REQ-040 Two-byte frame, preload 0x11, load 0x22 after the first load -> MISO returns 0x11 then 0x22; RX_DV pulses twice; no underrun.
REQ-041 Frame with an empty TX buffer -> MISO returns 0x00; one o_TX_Underrun pulse.
REQ-042 CS_n rises after 5 bits -> one o_Frame_Err pulse; no o_RX_DV; the next frame receives 0x5A correctly.
REQ-043 rst asserted after 3 bits -> outputs match REQ-036 immediately; a following frame sending 0xFF receives 0xFF.

Source files
------------

// File: rtl/spi_slave.sv
// SPI slave, modes 0-3, with clk-domain oversampling of the SPI pins.
// One-byte TX holding buffer in front of the TX shift register; byte-wide RX.
module spi_slave #(
    parameter int SPI_MODE    = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SPI_CLK,
    input  logic       CS_n,
    input  logic       MOSI,
    output logic       MISO,
    output logic       o_MISO_OE,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_TX_DV,
    output logic       o_TX_Ready,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_DV,
    output logic       o_TX_Underrun,
    output logic       o_Frame_Err,
    output logic       o_Busy
);

    localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
    localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] vld_q;
    logic                   sclk_d1_q;
    logic                   cs_d1_q;
    logic                   mosi_d1_q;

    logic sclk_s, cs_s;
    logic cs_fall, cs_rise, sclk_chg;
    logic lead_e, trail_e, cap_e, shf_e;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_sr_q, rx_sr_d;
    logic [7:0] tx_sr_q, tx_sr_d;
    logic [7:0] tx_buf_q, tx_buf_d;
    logic       tx_full_q, tx_full_d;
    logic       miso_q, miso_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rx_dv_q, rx_dv_d;
    logic       undr_q, undr_d;
    logic       ferr_q, ferr_d;
    logic       pend_q, pend_d;
    logic       arm_q, arm_d;
    logic       tx_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= {SYNC_STAGES{CPOL}};
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            vld_q       <= '0;
            sclk_d1_q   <= CPOL;
            cs_d1_q     <= 1'b1;
            mosi_d1_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SPI_CLK};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            vld_q       <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            sclk_d1_q   <= sclk_s;
            cs_d1_q     <= cs_s;
            mosi_d1_q   <= mosi_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign cs_fall  = cs_d1_q & ~cs_s;
    assign cs_rise  = ~cs_d1_q & cs_s;
    assign sclk_chg = ~cs_s & (sclk_s != sclk_d1_q);
    assign lead_e   = sclk_chg & (sclk_s != CPOL);
    assign trail_e  = sclk_chg & (sclk_s == CPOL);
    assign cap_e    = CPHA ? trail_e : lead_e;
    assign shf_e    = CPHA ? lead_e : trail_e;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_sr_d   = rx_sr_q;
        tx_sr_d   = tx_sr_q;
        tx_buf_d  = tx_buf_q;
        tx_full_d = tx_full_q;
        miso_d    = miso_q;
        rx_byte_d = rx_byte_q;
        rx_dv_d   = 1'b0;
        undr_d    = 1'b0;
        ferr_d    = 1'b0;
        pend_d    = pend_q;
        // Arm only once a real CS_n high has been seen after reset
        arm_d     = arm_q | (vld_q[SYNC_STAGES-1] & cs_s);
        tx_load   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cs_fall && arm_q) begin
                    state_d   = ACTIVE;
                    bit_cnt_d = 3'd7;
                    miso_d    = 1'b0;
                    pend_d    = 1'b0;
                    tx_load   = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d   = IDLE;
                    bit_cnt_d = 3'd7;
                    pend_d    = 1'b0;
                    ferr_d    = (bit_cnt_q != 3'd7);
                end else begin
                    if (cap_e) begin
                        rx_sr_d   = {rx_sr_q[6:0], mosi_d1_q};
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        if (bit_cnt_q == 3'd0) begin
                            rx_byte_d = {rx_sr_q[6:0], mosi_d1_q};
                            rx_dv_d   = 1'b1;
                            tx_load   = CPHA;
                        end
                        // An empty reload only counts once its byte is clocked
                        if (bit_cnt_q == 3'd7 && pend_q) begin
                            undr_d = 1'b1;
                            pend_d = 1'b0;
                        end
                    end
                    if (shf_e) begin
                        if (CPHA) begin
                            miso_d  = tx_sr_q[7];
                            tx_sr_d = {tx_sr_q[6:0], 1'b0};
                        end else if (bit_cnt_q == 3'd7) begin
                            tx_load = 1'b1;
                        end else begin
                            tx_sr_d = {tx_sr_q[6:0], 1'b0};
                        end
                    end
                end
            end
        endcase

        if (tx_load) begin
            if (tx_full_q) begin
                tx_sr_d   = tx_buf_q;
                tx_full_d = 1'b0;
            end else if (i_TX_DV) begin
                tx_sr_d = i_TX_Byte;
            end else begin
                tx_sr_d = 8'h00;
                if (state_q == IDLE) undr_d = 1'b1;
                else                 pend_d = 1'b1;
            end
        end else if (i_TX_DV && !tx_full_q) begin
            tx_buf_d  = i_TX_Byte;
            tx_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd7;
            rx_sr_q   <= 8'h00;
            tx_sr_q   <= 8'h00;
            tx_buf_q  <= 8'h00;
            tx_full_q <= 1'b0;
            miso_q    <= 1'b0;
            rx_byte_q <= 8'h00;
            rx_dv_q   <= 1'b0;
            undr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            pend_q    <= 1'b0;
            arm_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_sr_q   <= rx_sr_d;
            tx_sr_q   <= tx_sr_d;
            tx_buf_q  <= tx_buf_d;
            tx_full_q <= tx_full_d;
            miso_q    <= miso_d;
            rx_byte_q <= rx_byte_d;
            rx_dv_q   <= rx_dv_d;
            undr_q    <= undr_d;
            ferr_q    <= ferr_d;
            pend_q    <= pend_d;
            arm_q     <= arm_d;
        end
    end

    assign MISO          = (state_q == ACTIVE) && (CPHA ? miso_q : tx_sr_q[7]);
    assign o_MISO_OE     = (state_q == ACTIVE) && !cs_s;
    assign o_TX_Ready    = ~tx_full_q;
    assign o_RX_Byte     = rx_byte_q;
    assign o_RX_DV       = rx_dv_q;
    assign o_TX_Underrun = undr_q;
    assign o_Frame_Err   = ferr_q;
    assign o_Busy        = (state_q == ACTIVE);

endmodule
